ones_pattern_gen: RTL

- Generator side of the 7-input ones counter. It drives a WIDTH-bit line vector so that the number of asserted lines reaches a requested count.
- Lines change one at a time in circular order:
  - Ones are added at a head pointer.
  - Ones are removed at a tail pointer.
  - This is the same fill-then-release ordering the counter benches use.
- It sits upstream of the ones counter as a self-timed stimulus source with a valid/ready request port.

---
 rtl/ones_pattern_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: drives a WIDTH-bit line vector one line at a time until its popcount reaches a requested count
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_count           target number of asserted lines (clamped to WIDTH)
//   pat_out             driven line vector; ones occupy the circular window [tail, head)
//   cur_count           number of ones currently in pat_out
//   busy                high while stepping toward the target
//   done                one-cycle completion pulse
//   chk_err             sticky self-check error; tied low unless ONES_PATTERN_GEN_CHECK_EN is defined
//
// Build option: define ONES_PATTERN_GEN_CHECK_EN to build the popcount/pointer consistency checker.
module ones_pattern_gen #(
  parameter int WIDTH    = 7,
  parameter int CNT_W    = 3,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  output logic [WIDTH-1:0] pat_out,
  output logic [CNT_W-1:0] cur_count,
  output logic             busy,
  output logic             done,
  output logic             chk_err
);
  localparam int PW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int PS_W = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] W_C = CNT_W'(WIDTH);
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  state_t state, state_d;
  logic [PW-1:0] head, tail, head_d, tail_d;
  logic [CNT_W-1:0] tgt, tgt_d, cnt_d, req_tgt;
  logic [WIDTH-1:0] pat_d;
  logic [PS_W-1:0] ps, ps_d;
  logic up, tick;
  assign req_tgt = req_count > W_C ? W_C : req_count;
  assign up = cur_count < tgt;
  assign tick = ps == PS_LAST;
  always_comb begin
    state_d = state;
    pat_d   = pat_out;
    cnt_d   = cur_count;
    head_d  = head;
    tail_d  = tail;
    tgt_d   = tgt;
    ps_d    = ps;
    case (state)
      IDLE: if (req_valid) begin
        tgt_d   = req_tgt;
        ps_d    = '0;
        state_d = req_tgt == cur_count ? DONE : STEP;
      end
      STEP: begin
        ps_d = tick ? '0 : ps + 1'b1;
        if (tick) begin
          // fill at head, release at tail: the ones stay one contiguous circular run
          if (up) begin
            pat_d[head] = 1'b1;
            head_d      = head == LAST ? '0 : head + 1'b1;
            cnt_d       = cur_count + 1'b1;
          end else begin
            pat_d[tail] = 1'b0;
            tail_d      = tail == LAST ? '0 : tail + 1'b1;
            cnt_d       = cur_count - 1'b1;
          end
          state_d = cnt_d == tgt ? DONE : STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_out   <= '0;
      cur_count <= '0;
      head      <= '0;
      tail      <= '0;
      tgt       <= '0;
      ps        <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      pat_out   <= pat_d;
      cur_count <= cnt_d;
      head      <= head_d;
      tail      <= tail_d;
      tgt       <= tgt_d;
      ps        <= ps_d;
      // status flags are registered from the next state so they line up with it
      req_ready <= state_d == IDLE;
      busy      <= state_d == STEP;
      done      <= state_d == DONE;
    end
  end
`ifdef ONES_PATTERN_GEN_CHECK_EN
  logic [CNT_W-1:0] pop;
  int sum;
  logic bad;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + CNT_W'(pat_out[i]);
    // tail + count is below 2*WIDTH, so one conditional subtract is the modulo
    sum = int'(tail) + int'(cur_count);
    bad = pop != cur_count || int'(head) != (sum >= WIDTH ? sum - WIDTH : sum);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err <= 1'b0;
    else if (bad) chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif
endmodule
